// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider arbiter: FSM state encoding,
// default widths and an elaboration-time log2 helper.
package div_arb_pkg;

  localparam int DEF_W   = 10;
  localparam int DEF_TMO = 31;
  localparam int ST_W    = 3;

  typedef enum logic [ST_W-1:0] {
    ST_INIT,
    ST_IDLE,
    ST_LAUNCH,
    ST_GUARD,
    ST_WAIT,
    ST_FLUSH,
    ST_DELIVER
  } arb_state_e;

  // ceil(log2(v)); returns 0 for v <= 1
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_arbiter_if.sv
// Operand/result bus between the arbiter and the sequential divider core.
interface div_arbiter_if #(
  parameter int W = div_arb_pkg::DEF_W
);
  logic [W-1:0] div_a;
  logic [W-1:0] div_b;
  logic         div_start;
  logic         div_sclr;
  logic         div_busy;
  logic         div_valid;
  logic [W-1:0] div_q;
  logic         div_dvz;
  logic         div_ovf;

  modport master (
    output div_a, div_b, div_start, div_sclr,
    input  div_busy, div_valid, div_q, div_dvz, div_ovf
  );

  modport slave (
    input  div_a, div_b, div_start, div_sclr,
    output div_busy, div_valid, div_q, div_dvz, div_ovf
  );
endinterface

// File: rtl/div_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr+1 (mod N).
// Purely combinational; returns one-hot grant plus binary index.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic [PW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 1; i <= N; i++) begin
      cand = PW'((int'(ptr) + i) % N);
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one sequential divider core between N requesters: grant, load,
// start, wait for completion (with watchdog flush), then return the result.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int N          = 2,
  parameter int W          = DEF_W,
  parameter int TMO_CYCLES = DEF_TMO
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_bus,
  input  logic [N*W-1:0] b_bus,
  output logic [N-1:0]   ack,
  output logic [N-1:0]   done,
  output logic [W-1:0]   res_q,
  output logic           res_dvz,
  output logic           res_ovf,
  output logic           res_tmo,
  output logic           arb_busy,
  div_arbiter_if.master  core
);

  localparam int PW = (clog2(N) < 1) ? 1 : clog2(N);
  localparam int TW = clog2(TMO_CYCLES) + 1;

  arb_state_e    state_q, state_d;
  logic [PW-1:0] ptr_q,   ptr_d;
  logic [TW-1:0] tmr_q,   tmr_d;
  logic [N-1:0]  ack_q,   ack_d;
  logic [N-1:0]  done_q,  done_d;
  logic          start_q, start_d;
  logic [W-1:0]  opa_q,   opa_d;
  logic [W-1:0]  opb_q,   opb_d;
  logic [W-1:0]  quo_q,   quo_d;
  logic          dvz_q,   dvz_d;
  logic          ovf_q,   ovf_d;
  logic          tmo_q,   tmo_d;

  logic [N-1:0]  gnt;
  logic [PW-1:0] win;
  logic          any_req;

  // Completion is decided by state alone; busy is only a debug aid.
  logic unused_busy;
  assign unused_busy = core.div_busy;

  rr_pick #(.N(N), .PW(PW)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (win),
    .any (any_req)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    tmr_d   = tmr_q;
    ack_d   = '0;
    done_d  = '0;
    start_d = 1'b0;
    opa_d   = opa_q;
    opb_d   = opb_q;
    quo_d   = quo_q;
    dvz_d   = dvz_q;
    ovf_d   = ovf_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_INIT: state_d = ST_IDLE;
      ST_IDLE: begin
        if (any_req) begin
          opa_d   = a_bus[win*W +: W];
          opb_d   = b_bus[win*W +: W];
          ack_d   = gnt;
          ptr_d   = win;
          start_d = 1'b1;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        tmr_d   = '0;
        state_d = ST_GUARD;
      end
      // A valid still asserted from the previous op is not trusted here.
      ST_GUARD: state_d = ST_WAIT;
      ST_WAIT: begin
        tmr_d = tmr_q + TW'(1);
        if (core.div_valid) begin
          quo_d        = core.div_q;
          dvz_d        = core.div_dvz;
          ovf_d        = core.div_ovf;
          tmo_d        = 1'b0;
          done_d[ptr_q] = 1'b1;
          state_d      = ST_DELIVER;
        end else if (tmr_q == TW'(TMO_CYCLES - 1)) begin
          quo_d   = '0;
          dvz_d   = 1'b0;
          ovf_d   = 1'b0;
          tmo_d   = 1'b1;
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        done_d[ptr_q] = 1'b1;
        state_d       = ST_DELIVER;
      end
      ST_DELIVER: state_d = ST_IDLE;
      default:    state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      ptr_q   <= PW'(N - 1);
      tmr_q   <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      start_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      quo_q   <= '0;
      dvz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      tmr_q   <= tmr_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      start_q <= start_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      quo_q   <= quo_d;
      dvz_q   <= dvz_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
    end
  end

  assign ack            = ack_q;
  assign done           = done_q;
  assign res_q          = quo_q;
  assign res_dvz        = dvz_q;
  assign res_ovf        = ovf_q;
  assign res_tmo        = tmo_q;
  assign arb_busy       = (state_q != ST_IDLE);
  assign core.div_a     = opa_q;
  assign core.div_b     = opb_q;
  assign core.div_start = start_q;
  // Held in INIT so the core is cleared across reset and one cycle after.
  assign core.div_sclr  = (state_q == ST_INIT) || (state_q == ST_FLUSH);

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
Shares one sequential 10-bit divider core between N requesters. Sequences the core: operand load, start pulse, completion wait, result return. Adds a watchdog timeout with core flush. Sits between client blocks and the divider top; sole driver of the core's operand, start and sclr inputs.

Parameters:
N, 2, number of requesters (2..8)
W, 10, operand/quotient width; must match the divider core
TMO_CYCLES, 31, maximum WAIT cycles before the watchdog fires (>= core latency + 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  N  per-requester request level; held with operands until ack
a_bus  input  N*W  dividends, requester i at [i*W +: W]
b_bus  input  N*W  divisors, same packing
ack  output  N  one-hot, one-cycle pulse: operands captured
done  output  N  one-hot, one-cycle pulse: result valid on res_*
res_q  output  W  quotient
res_dvz  output  1  divide-by-zero flag
res_ovf  output  1  overflow flag
res_tmo  output  1  watchdog timeout flag
arb_busy  output  1  high whenever state != IDLE
div_a  output  W  to core dividend
div_b  output  W  to core divisor
div_start  output  1  to core start
div_sclr  output  1  to core synchronous clear
div_busy  input  1  from core
div_valid  input  1  from core; may stay high until next start
div_q  input  W  from core
div_dvz  input  1  from core
div_ovf  input  1  from core

Behaviour:
- States: INIT, IDLE, LAUNCH, GUARD, WAIT, FLUSH, DELIVER. Reset state: INIT.
- Reset values: ack, done, div_start, res_* = 0; div_a, div_b = 0; rr pointer = N-1; timer = 0. div_sclr = (state==INIT || state==FLUSH), so it is high throughout reset and for the first cycle after release.
- INIT -> IDLE unconditionally.
- IDLE:
  - If any req, pick the winner round-robin, starting at ptr+1 mod N.
  - Latch a_bus/b_bus slice into div_a/div_b. Pulse ack[winner]. ptr <= winner. Go LAUNCH.
  - With no req, stay in IDLE.
- LAUNCH: div_start = 1 for exactly this cycle. Timer cleared. -> GUARD.
- GUARD: one cycle. div_valid is ignored here, so a stale valid from the previous op is never taken as completion. -> WAIT.
- WAIT: timer increments every cycle.
  - If div_valid: capture div_q, div_dvz, div_ovf into res_*; res_tmo = 0; -> DELIVER.
  - Else if timer == TMO_CYCLES-1: res_q = 0, res_dvz = res_ovf = 0, res_tmo = 1; -> FLUSH.
  - If valid and timeout occur in the same cycle, valid wins.
- FLUSH: div_sclr = 1 for one cycle. -> DELIVER.
- DELIVER: done[ptr] = 1 for one cycle. -> IDLE.
- res_* hold their value until the next capture.
- div_a/div_b hold from grant until the next grant.
- ack/done/div_start are registered, glitch-free outputs.
- Minimum grant-to-grant spacing: LAUNCH + GUARD + 1 WAIT + DELIVER + IDLE = 5 cycles.
- Request dropped before ack: never granted. No partial capture.
- Request re-asserted right after its own done: yields to any other pending requester.
- div_busy is informational only. It does not gate state transitions.
- rst_n asserted mid-operation: immediate return to INIT. No done is issued for the in-flight op. The core is cleared via div_sclr.
- Width: all data paths are W bits. Timer width = clog2(TMO_CYCLES)+1.

Decomposition:
- Package div_arb_pkg: state enum, state encoding width, clog2 helper, default W/TMO constants.
- One combinational sub-module, rr_pick: inputs req[N] and ptr; outputs a one-hot grant and a binary index.

Test Plan:
- Single op: req[0]=1, a=100, b=7; core model 12-cycle latency -> ack[0] one cycle later; div_start one pulse; done[0] with res_q=14, dvz=0, ovf=0, tmo=0.
- Contention: req=2'b11 held from reset, ptr=N-1 -> grant order 0,1,0,1. Each done matches its operands (0: 50/5=10; 1: 999/3=333).
- Divide by zero: a=10, b=0; core raises valid+dvz after 2 cycles -> done with res_dvz=1. A stale valid during GUARD must not complete early.
- Watchdog: core model never raises valid -> after TMO_CYCLES WAIT cycles, div_sclr pulses once, then done with res_tmo=1, res_q=0.
- Reset mid-WAIT: drop rst_n at WAIT cycle 5 -> outputs at reset values; div_sclr high during reset and the cycle after; no done; next req is served normally.
- Back-to-back: requester 0 re-asserts in the cycle after its done while requester 1 is idle -> granted again in IDLE with correct result.
